// File: rtl/inv_pulse_driver.sv
// Stimulus stage for an RSFQ inverter: buffers data bits in a FIFO and, per bit, emits an
// optional d pulse followed T_SETUP cycles later by a clk pulse, counting clk pulses issued.
module inv_pulse_driver #(
  parameter int unsigned T_SETUP  = 10,
  parameter int unsigned T_PERIOD = 40,
  parameter int unsigned PW       = 2,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        d_pulse,
  output logic        clk_pulse,
  output logic        busy,
  output logic        bit_done,
  output logic [15:0] pulse_count
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PhW = $clog2(T_PERIOD + 1);

  localparam logic [PhW-1:0] PhLast     = PhW'(T_PERIOD - 1);
  localparam logic [PhW-1:0] PhSetup    = PhW'(T_SETUP);
  localparam logic [PhW-1:0] PhSetupEnd = PhW'(T_SETUP + PW);
  localparam logic [PhW-1:0] PhPw       = PhW'(PW);
  localparam logic [PhW-1:0] PhOne      = PhW'(1);
  localparam logic [AW:0]    PtrOne     = (AW + 1)'(1);

  if (PW < 1 || T_SETUP < PW || T_PERIOD < T_SETUP + 2 * PW || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
    $fatal(1, "inv_pulse_driver: illegal T_SETUP/T_PERIOD/PW/DEPTH combination");
  end

  typedef enum logic {StIdle, StActive} state_e;

  state_e           state_q;
  logic [PhW-1:0]   ph_q;
  logic             cur_bit_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [DEPTH-1:0] mem_q;
  logic [15:0]      pulse_count_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic slot_end;
  logic head;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Push ignores a same-cycle pop: ready never looks ahead.
    push     = in_valid && !full;
    slot_end = (state_q == StActive) && (ph_q == PhLast);
    pop      = !empty && ((state_q == StIdle) || slot_end);
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ph_q          <= '0;
      cur_bit_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pulse_count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrOne;
        cur_bit_q <= head;
        ph_q      <= '0;
        state_q   <= StActive;
      end else if (state_q == StActive) begin
        if (slot_end) begin
          ph_q    <= '0;
          state_q <= StIdle;
        end else begin
          ph_q <= ph_q + PhOne;
        end
      end
      if ((state_q == StActive) && (ph_q == PhSetup)) begin
        pulse_count_q <= pulse_count_q + 16'd1;
      end
    end
  end

  // Outputs depend on registered state only, so nothing combinational reaches the cell.
  assign in_ready    = !full;
  assign busy        = (state_q == StActive);
  assign d_pulse     = busy && cur_bit_q && (ph_q < PhPw);
  assign clk_pulse   = busy && (ph_q >= PhSetup) && (ph_q < PhSetupEnd);
  assign bit_done    = slot_end;
  assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_inv_pulse_driver.sv
// Self-checking bench for inv_pulse_driver: each slot is modelled as a start cycle derived
// from its acceptance time, and all outputs are recomputed from that slot list every cycle.
module tb_inv_pulse_driver;

  localparam int TS  = 10;
  localparam int TP  = 40;
  localparam int PWL = 2;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_ready;
  logic        d_pulse;
  logic        clk_pulse;
  logic        busy;
  logic        bit_done;
  logic [15:0] pulse_count;

  inv_pulse_driver #(
    .T_SETUP (TS),
    .T_PERIOD(TP),
    .PW      (PWL),
    .DEPTH   (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .d_pulse    (d_pulse),
    .clk_pulse  (clk_pulse),
    .busy       (busy),
    .bit_done   (bit_done),
    .pulse_count(pulse_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   start;
    logic b;
  } slot_t;

  // Cycle k is the interval following posedge k; every accepted bit owns one slot.
  slot_t       q[$];
  logic [15:0] base = '0;
  int          last_start = -1000;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [20:0] obs_v;
  logic [20:0] exp_v;
  logic        dh[64];

  always @(negedge clk) dh[cyc % 64] <= d_pulse;

  function automatic int occ_at(int k);
    int n = 0;
    foreach (q[i]) if (q[i].start > k) n++;
    return n;
  endfunction

  function automatic logic [20:0] exp_out(int k);
    logic        d = 1'b0, c = 1'b0, b = 1'b0, dn = 1'b0;
    logic [15:0] cnt = base;
    int          ph;
    foreach (q[i]) begin
      if (q[i].start + TS < k) cnt = cnt + 16'd1;
      if (q[i].start <= k && k < q[i].start + TP) begin
        ph = k - q[i].start;
        b  = 1'b1;
        d  = q[i].b && (ph < PWL);
        c  = (ph >= TS) && (ph < TS + PWL);
        dn = (ph == TP - 1);
      end
    end
    return {occ_at(k) < DEP, d, c, b, dn, cnt};
  endfunction

  // Advances one clock and updates the slot list; a bit waiting in an idle FIFO starts
  // one cycle after acceptance, otherwise right after the previous slot.
  task automatic tick();
    logic  rdy;
    int    s;
    slot_t t;
    rdy = (occ_at(cyc) < DEP);
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      base       = '0;
      last_start = -1000;
    end else begin
      while (q.size() > 0 && q[0].start + TP <= cyc) begin
        void'(q.pop_front());
        base = base + 16'd1;
      end
      if (in_valid && rdy) begin
        s          = (cyc + 1 > last_start + TP) ? cyc + 1 : last_start + TP;
        t.start    = s;
        t.b        = in_bit;
        q.push_back(t);
        last_start = s;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    for (int n = 0; n < 100; n++) begin
      tick();
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_single_bit();
    int e0, d_rise = -1, c_rise = -1, done_c = -1;
    logic busy_after = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_bit = 1'b1;
    e0 = cyc + 1;
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 50; n++) begin
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single_bit cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (d_pulse === 1'b1 && d_rise < 0) d_rise = cyc;
      if (clk_pulse === 1'b1 && c_rise < 0) c_rise = cyc;
      if (done_c >= 0 && cyc == done_c + 1) busy_after = busy;
      if (bit_done === 1'b1 && done_c < 0) done_c = cyc;
      tick();
    end
    // The pop edge follows the acceptance edge; the slot's first cycle comes right after it.
    checks++;
    if (d_rise != e0 + 1) begin
      errors++;
      $display("FAIL single_d_rise got=%0d exp=%0d", d_rise, e0 + 1);
    end
    checks++;
    if (c_rise - d_rise != TS) begin
      errors++;
      $display("FAIL single_clk_delay got=%0d exp=%0d", c_rise - d_rise, TS);
    end
    checks++;
    if (done_c - d_rise != TP - 1) begin
      errors++;
      $display("FAIL single_done got=%0d exp=%0d", done_c - d_rise, TP - 1);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_after got=%b exp=0", busy_after);
    end
    checks++;
    if (pulse_count !== 16'd1) begin
      errors++;
      $display("FAIL single_count got=%0d exp=1", pulse_count);
    end
  endtask

  task automatic test_back_to_back();
    logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   rises[$];
    logic seen[$];
    logic prev_c = 1'b0, started = 1'b0;
    int   dones = 0, gap = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 190; n++) begin
      in_valid = (n < 4);
      in_bit   = (n < 4) ? pat[n] : 1'b0;
      tick();
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (clk_pulse === 1'b1 && !prev_c) begin
        rises.push_back(cyc);
        seen.push_back(dh[(cyc - TS) % 64]);
      end
      prev_c = clk_pulse;
      if (busy === 1'b1) started = 1'b1;
      if (started && dones < 4 && busy !== 1'b1) gap++;
      if (bit_done === 1'b1) dones++;
    end
    in_valid = 1'b0;
    checks++;
    if (rises.size() != 4 || seen.size() != 4) begin
      errors++;
      $display("FAIL b2b_rises got=%0d exp=4", rises.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (rises[i] - rises[i-1] != TP) begin
          errors++;
          $display("FAIL b2b_spacing slot=%0d got=%0d exp=%0d", i, rises[i] - rises[i-1], TP);
        end
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== pat[i]) begin
          errors++;
          $display("FAIL b2b_dbit slot=%0d got=%b exp=%b", i, seen[i], pat[i]);
        end
      end
    end
    checks++;
    if (gap != 0) begin
      errors++;
      $display("FAIL b2b_gap got=%0d exp=0", gap);
    end
    checks++;
    if (pulse_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=4", pulse_count);
    end
  endtask

  task automatic test_full_fifo();
    logic bits[6];
    logic seen[$];
    logic prev_c = 1'b0, saw_block = 1'b0;
    int   hs = 0, hs_edge = -1, first_done = -1;
    foreach (bits[i]) bits[i] = 1'($urandom_range(0, 1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL full cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (clk_pulse === 1'b1 && !prev_c) seen.push_back(dh[(cyc - TS) % 64]);
      prev_c = clk_pulse;
      if (bit_done === 1'b1 && first_done < 0) first_done = cyc;
      if (hs == 5 && in_ready === 1'b0) saw_block = 1'b1;
      if (hs < 6) begin
        in_valid = 1'b1;
        in_bit   = bits[hs];
        if (in_ready === 1'b1) begin
          hs++;
          hs_edge = cyc + 1;
        end
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (!saw_block) begin
      errors++;
      $display("FAIL full_ready_drop got=never exp=in_ready low with 5 accepted");
    end
    checks++;
    if (hs_edge <= first_done + 1) begin
      errors++;
      $display("FAIL full_sixth_hold got=%0d exp>%0d", hs_edge, first_done + 1);
    end
    checks++;
    if (seen.size() != 6) begin
      errors++;
      $display("FAIL full_count got=%0d exp=6", seen.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seen[i] !== bits[i]) begin
          errors++;
          $display("FAIL full_order slot=%0d got=%b exp=%b", i, seen[i], bits[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int   found = 0, stray = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rst_mid_pre cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (clk_pulse === 1'b1) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL rst_mid_wait got=no clk_pulse exp=clk_pulse within 60 cycles");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({clk_pulse, busy, in_ready, pulse_count} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL rst_mid_after got=%b%b%b/%0d exp=001/0", clk_pulse, busy, in_ready,
               pulse_count);
    end
    for (int n = 0; n < 100; n++) begin
      tick();
      if (d_pulse !== 1'b0 || clk_pulse !== 1'b0 || busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0 || pulse_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_quiet got=%0d stray/%0d count exp=0/0", stray, pulse_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 900; n++) begin
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = (n < 450) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      in_bit   = 1'($urandom_range(0, 1));
      tick();
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] prev = '0;
    logic        saw_wrap = 1'b0;
    for (int n = 0; n < 300 && (q.size() != 0 || busy === 1'b1); n++) tick();
    checks++;
    if (q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wrap_drain got=busy exp=idle");
    end
    force dut.pulse_count_q = 16'hFFFE;
    base = 16'hFFFE;
    #1;
    release dut.pulse_count_q;
    for (int n = 0; n < 200; n++) begin
      in_valid = (n < 4);
      in_bit   = 1'($urandom_range(0, 1));
      tick();
      obs_v = {in_ready, d_pulse, clk_pulse, busy, bit_done, pulse_count};
      exp_v = exp_out(cyc);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL wrap cyc=%0d got=%h exp=%h", cyc, obs_v, exp_v);
      end
      if (prev == 16'hFFFF && pulse_count === 16'h0000) saw_wrap = 1'b1;
      prev = pulse_count;
    end
    in_valid = 1'b0;
    checks++;
    if (!saw_wrap || pulse_count !== 16'd2) begin
      errors++;
      $display("FAIL wrap_step got=wrap:%b count:%h exp=wrap:1 count:0002", saw_wrap,
               pulse_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=completion");
    $fatal(1, "watchdog expired");
  end

endmodule
